led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 132 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives four LEDs through one of four patterns. A prescaler sets the step
//   rate, with one step every TICK_DIV clock cycles. A two-state FSM
//   (IDLE/RUN) follows the enable level.
//
// Ports
//   i_clk        system clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     1 = run the selected pattern, 0 = LEDs dark, sequencer idle
//   i_mode       requested pattern: 00 ALL_BLINK, 01 CHASE, 10 BOUNCE, 11 BINARY
//   i_mode_load  one-cycle strobe that captures i_mode (restarts a running pattern)
//   o_led        registered LED drive, bit 0 = led_1 ... bit 3 = led_4, 1 = on
//   o_tick       registered one-cycle pulse on every pattern step
//   o_mode       current mode register
//   o_busy       1 while the FSM is in RUN
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    input  logic       i_mode_load,
    output logic [3:0] o_led,
    output logic       o_tick,
    output logic [1:0] o_mode,
    output logic       o_busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] MODE_ALL_BLINK = 2'b00;
    localparam logic [1:0] MODE_CHASE     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE    = 2'b10;
    localparam logic [1:0] MODE_BINARY    = 2'b11;

    localparam logic             DIR_UP    = 1'b1;
    localparam logic [CNT_W-1:0] PRESC_TOP = CNT_W'(TICK_DIV - 32'd1);

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] presc_reg, presc_next;
    logic [3:0]       led_reg, led_next;
    logic             tick_reg, tick_next;
    logic             dir_reg, dir_next;
    logic [1:0]       mode_reg, mode_next;

    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        case (m)
            MODE_ALL_BLINK: init_pattern = 4'b1111;
            MODE_BINARY:    init_pattern = 4'b0000;
            default:        init_pattern = 4'b0001;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        led_next   = led_reg;
        tick_next  = 1'b0;
        dir_next   = dir_reg;
        mode_next  = i_mode_load ? i_mode : mode_reg;

        if (!i_enable) begin
            state_next = IDLE;
            presc_next = '0;
            led_next   = 4'b0000;
            dir_next   = DIR_UP;
        end else if (state_reg == IDLE || i_mode_load) begin
            // Entry to RUN and any mode load share the restart path; a load
            // therefore wins over a coincident prescaler wrap.
            state_next = RUN;
            presc_next = '0;
            led_next   = init_pattern(mode_next);
            dir_next   = DIR_UP;
        end else if (presc_reg == PRESC_TOP) begin
            presc_next = '0;
            tick_next  = 1'b1;
            case (mode_reg)
                MODE_ALL_BLINK: led_next = ~led_reg;
                MODE_CHASE:     led_next = {led_reg[2:0], led_reg[3]};
                MODE_BOUNCE: begin
                    // Turn around on the end LED itself so the end value
                    // is never shown twice in a row.
                    if (dir_reg == DIR_UP) begin
                        if (led_reg[3]) begin
                            led_next = led_reg >> 1;
                            dir_next = ~DIR_UP;
                        end else begin
                            led_next = led_reg << 1;
                        end
                    end else begin
                        if (led_reg[0]) begin
                            led_next = led_reg << 1;
                            dir_next = DIR_UP;
                        end else begin
                            led_next = led_reg >> 1;
                        end
                    end
                end
                default:        led_next = led_reg + 4'd1;
            endcase
        end else begin
            presc_next = presc_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            led_reg   <= 4'b0000;
            tick_reg  <= 1'b0;
            dir_reg   <= DIR_UP;
            mode_reg  <= MODE_ALL_BLINK;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            led_reg   <= led_next;
            tick_reg  <= tick_next;
            dir_reg   <= dir_next;
            mode_reg  <= mode_next;
        end
    end

    assign o_led  = led_reg;
    assign o_tick = tick_reg;
    assign o_mode = mode_reg;
    assign o_busy = (state_reg == RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Table-driven bench for led_pattern_sequencer with TICK_DIV = 4. Each
//   table row is one clock cycle: the inputs driven before the edge and the
//   outputs expected after it. The asynchronous reset case is written out
//   by hand after the table.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic       mode_load;
    logic [3:0] led;
    logic       tick;
    logic [1:0] mode_out;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    led_pattern_sequencer #(
        .TICK_DIV(4),
        .CNT_W   (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_mode     (mode),
        .i_mode_load(mode_load),
        .o_led      (led),
        .o_tick     (tick),
        .o_mode     (mode_out),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic       ld;
        logic [3:0] exp_led;
        logic       exp_tick;
        logic [1:0] exp_mode;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic en, input logic [1:0] md, input logic ld,
                        input logic [3:0] e_led, input logic e_tick,
                        input logic [1:0] e_mode, input logic e_busy);
        vec_t v;
        v.en = en; v.md = md; v.ld = ld;
        v.exp_led = e_led; v.exp_tick = e_tick;
        v.exp_mode = e_mode; v.exp_busy = e_busy;
        vecs.push_back(v);
    endtask

    // One pattern step: three quiet cycles, then the tick cycle showing the
    // next pattern. i_mode is driven to a different value without a load to
    // show that it has no effect.
    task automatic push_step(input logic [3:0] cur, input logic [3:0] nxt,
                             input logic [1:0] om);
        for (int k = 0; k < 3; k++) push(1'b1, ~om, 1'b0, cur, 1'b0, om, 1'b1);
        push(1'b1, ~om, 1'b0, nxt, 1'b1, om, 1'b1);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_led, input logic e_tick,
                             input logic [1:0] e_mode, input logic e_busy);
        check({tag, " led"},  led,             e_led);
        check({tag, " tick"}, {3'b000, tick},  {3'b000, e_tick});
        check({tag, " mode"}, {2'b00, mode_out}, {2'b00, e_mode});
        check({tag, " busy"}, {3'b000, busy},  {3'b000, e_busy});
    endtask

    logic [3:0] chase_seq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bounce_seq [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

    initial begin
        logic [3:0] cnt_a;
        logic [3:0] cnt_b;

        rst_n = 1'b0; enable = 1'b0; mode = 2'b00; mode_load = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", 4'b0000, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;

        // Load CHASE while idle, then enable.
        push(1'b0, 2'b01, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b0);
        push(1'b1, 2'b10, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) push_step(chase_seq[i], chase_seq[i+1], 2'b01);

        // Reloading the same mode mid-count restarts the prescaler.
        push(1'b1, 2'b01, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1);
        push(1'b1, 2'b01, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1);
        push(1'b1, 2'b01, 1'b1, 4'b0001, 1'b0, 2'b01, 1'b1);
        push_step(4'b0001, 4'b0010, 2'b01);

        // Load ALL_BLINK exactly on the wrap cycle: no tick, new pattern.
        for (int k = 0; k < 3; k++) push(1'b1, 2'b01, 1'b0, 4'b0010, 1'b0, 2'b01, 1'b1);
        push(1'b1, 2'b00, 1'b1, 4'b1111, 1'b0, 2'b00, 1'b1);
        push_step(4'b1111, 4'b0000, 2'b00);
        push_step(4'b0000, 4'b1111, 2'b00);

        // BOUNCE for 10 steps.
        push(1'b1, 2'b10, 1'b1, 4'b0001, 1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 10; i++) push_step(bounce_seq[i], bounce_seq[i+1], 2'b10);

        // Drop enable mid-bounce (direction down), then re-enable.
        push(1'b0, 2'b10, 1'b0, 4'b0000, 1'b0, 2'b10, 1'b0);
        push(1'b0, 2'b10, 1'b0, 4'b0000, 1'b0, 2'b10, 1'b0);
        push(1'b1, 2'b01, 1'b0, 4'b0001, 1'b0, 2'b10, 1'b1);
        push_step(4'b0001, 4'b0010, 2'b10);
        push_step(4'b0010, 4'b0100, 2'b10);

        // BINARY for 17 steps: counts through 1111, wraps to 0000, then 0001.
        push(1'b1, 2'b11, 1'b1, 4'b0000, 1'b0, 2'b11, 1'b1);
        cnt_a = 4'b0000;
        for (int i = 0; i < 17; i++) begin
            cnt_b = cnt_a + 4'd1;
            push_step(cnt_a, cnt_b, 2'b11);
            cnt_a = cnt_b;
        end

        // Load coinciding with enable falling, load while idle, load with entry.
        push(1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(1'b0, 2'b11, 1'b1, 4'b0000, 1'b0, 2'b11, 1'b0);
        push(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0, 2'b11, 1'b0);
        push(1'b1, 2'b00, 1'b1, 4'b1111, 1'b0, 2'b00, 1'b1);
        push_step(4'b1111, 4'b0000, 2'b00);
        push(1'b1, 2'b10, 1'b1, 4'b0001, 1'b0, 2'b10, 1'b1);

        foreach (vecs[i]) begin
            enable    = vecs[i].en;
            mode      = vecs[i].md;
            mode_load = vecs[i].ld;
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_tick,
                      vecs[i].exp_mode, vecs[i].exp_busy);
        end

        // Asynchronous reset between edges while running BOUNCE.
        enable = 1'b1; mode = 2'b10; mode_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all("pre_rst", 4'b0001, 1'b0, 2'b10, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 4'b0000, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        check_all("rst_held", 4'b0000, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("rst_rel", 4'b1111, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("rst_wait%0d", k), 4'b1111, 1'b0, 2'b00, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        check_all("rst_step", 4'b0000, 1'b1, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
